// File: rtl/debounce_sched.sv
// Round-robin debounce scheduler: one shared stability counter serves NB_BTN synchronized buttons.
// Macros: COCOTB_SIM shortens the debounce window; DEBOUNCE_FALL_EVT_EN adds the fall_o pulse output.
//
// state   | meaning
// S_IDLE  | counter free; grant the next pending input found from rr_ptr upward
// S_COUNT | counter owned by `owner`; count timepulses until commit or abort
module debounce_sched #(
    parameter int NB_BTN          = 4,
    parameter int PULSE_PER_NS    = 5120,
`ifdef COCOTB_SIM
    parameter int DEBOUNCE_PER_NS = 5120 * 8
`else
    parameter int DEBOUNCE_PER_NS = 20_971_520
`endif
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      tp_i,
    input  logic [NB_BTN-1:0]         btn_i,
    output logic [NB_BTN-1:0]         btn_o,
    output logic [NB_BTN-1:0]         rise_o,
    output logic                      busy_o,
    output logic [$clog2(NB_BTN)-1:0] grant_o
`ifdef DEBOUNCE_FALL_EVT_EN
    ,
    output logic [NB_BTN-1:0]         fall_o
`endif
);

    localparam int MAX_COUNT = DEBOUNCE_PER_NS / PULSE_PER_NS - 1;
    localparam int CW        = (MAX_COUNT > 0) ? $clog2(MAX_COUNT + 1) : 1;
    localparam int GW        = $clog2(NB_BTN);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_COUNT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [NB_BTN-1:0]   sync1_q, sync2_q;
    logic [NB_BTN-1:0]   pend;
    logic [2*NB_BTN-1:0] pend_dbl;
    logic [NB_BTN-1:0]   pend_rot;
    logic [GW-1:0]       owner_q, owner_d;
    logic [GW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]       owner_inc;
    logic [GW-1:0]       rot_ofs;
    logic [GW:0]         pick_sum;
    logic [GW-1:0]       pick;
    logic                found;
    logic [CW-1:0]       counter_q, counter_d;
    logic [NB_BTN-1:0]   btn_d, rise_d;
`ifdef DEBOUNCE_FALL_EVT_EN
    logic [NB_BTN-1:0]   fall_d;
`endif

    assign pend = sync2_q ^ btn_o;

    // Rotating the pending vector by rr_ptr turns the wrap-around search into a plain lowest-bit search.
    assign pend_dbl = {pend, pend} >> rr_ptr_q;
    assign pend_rot = pend_dbl[NB_BTN-1:0];

    always_comb begin
        found   = 1'b0;
        rot_ofs = '0;
        for (int k = NB_BTN - 1; k >= 0; k--) begin
            if (pend_rot[k]) begin
                found   = 1'b1;
                rot_ofs = GW'(k);
            end
        end
    end

    always_comb begin
        pick_sum = {1'b0, rr_ptr_q} + {1'b0, rot_ofs};
        if (pick_sum >= (GW + 1)'(NB_BTN)) begin
            pick_sum = pick_sum - (GW + 1)'(NB_BTN);
        end
        pick = pick_sum[GW-1:0];
    end

    assign owner_inc = (owner_q == GW'(NB_BTN - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        counter_d = counter_q;
        btn_d     = btn_o;
        rise_d    = '0;
`ifdef DEBOUNCE_FALL_EVT_EN
        fall_d    = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    owner_d   = pick;
                    counter_d = '0;
                    state_d   = S_COUNT;
                end
            end
            S_COUNT: begin
                // A bounce back to the committed level wins over a simultaneous terminal pulse.
                if (!pend[owner_q]) begin
                    state_d  = S_IDLE;
                    rr_ptr_d = owner_inc;
                end else if (tp_i) begin
                    if (counter_q == CW'(MAX_COUNT)) begin
                        btn_d[owner_q]  = sync2_q[owner_q];
                        rise_d[owner_q] = sync2_q[owner_q];
`ifdef DEBOUNCE_FALL_EVT_EN
                        fall_d[owner_q] = ~sync2_q[owner_q];
`endif
                        state_d         = S_IDLE;
                        rr_ptr_d        = owner_inc;
                    end else begin
                        counter_d = counter_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            state_q   <= S_IDLE;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            counter_q <= '0;
            btn_o     <= '0;
            rise_o    <= '0;
`ifdef DEBOUNCE_FALL_EVT_EN
            fall_o    <= '0;
`endif
        end else begin
            sync1_q   <= btn_i;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            counter_q <= counter_d;
            btn_o     <= btn_d;
            rise_o    <= rise_d;
`ifdef DEBOUNCE_FALL_EVT_EN
            fall_o    <= fall_d;
`endif
        end
    end

    assign busy_o  = (state_q == S_COUNT);
    assign grant_o = owner_q;

endmodule

// File: tb/tb_debounce_sched.sv
// Scoreboard bench for debounce_sched: a behavioural model predicts commits and grants,
// a monitor pops and compares each observed btn_o change.
module tb_debounce_sched;
    localparam int NB       = 4;
    localparam int MAXC     = 7;
    localparam int TP_EVERY = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tp = 1'b0;
    logic [NB-1:0] btn = '0;
    logic [NB-1:0] btn_o, rise_o;
    logic          busy_o;
    logic [1:0]    grant_o;
`ifdef DEBOUNCE_FALL_EVT_EN
    logic [NB-1:0] fall_o;
`endif

    debounce_sched #(
        .NB_BTN(NB),
        .PULSE_PER_NS(5120),
        .DEBOUNCE_PER_NS(5120 * 8)
    ) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .tp_i(tp),
        .btn_i(btn),
        .btn_o(btn_o),
        .rise_o(rise_o),
        .busy_o(busy_o),
        .grant_o(grant_o)
`ifdef DEBOUNCE_FALL_EVT_EN
        ,
        .fall_o(fall_o)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    function automatic void chk(string nm, int got, int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endfunction

    typedef struct {
        int idx;
        int val;
        int cyc;
    } ev_t;
    ev_t exp_q[$];

    // Behavioural model: inputs seen two edges late, one shared window of MAXC+1 pulses.
    int cyc = 0;
    int m_s1[NB];
    int m_s2[NB];
    int m_deb[NB];
    bit m_busy = 1'b0;
    int m_own = 0;
    int m_ptr = 0;
    int m_tps = 0;
    int cand;
    bit hit;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            for (int i = 0; i < NB; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0;
            end
            m_busy = 1'b0; m_own = 0; m_ptr = 0; m_tps = 0;
        end else begin
            if (m_busy) begin
                if (m_s2[m_own] == m_deb[m_own]) begin
                    m_busy = 1'b0;
                    m_ptr  = (m_own + 1) % NB;
                end else if (tp) begin
                    m_tps++;
                    if (m_tps == MAXC + 1) begin
                        m_deb[m_own] = m_s2[m_own];
                        exp_q.push_back('{m_own, m_deb[m_own], cyc});
                        m_busy = 1'b0;
                        m_ptr  = (m_own + 1) % NB;
                    end
                end
            end else begin
                hit = 1'b0;
                for (int k = 0; k < NB; k++) begin
                    cand = (m_ptr + k) % NB;
                    if (!hit && m_s2[cand] != m_deb[cand]) begin
                        hit = 1'b1; m_busy = 1'b1; m_own = cand; m_tps = 0;
                    end
                end
            end
            for (int i = 0; i < NB; i++) begin
                m_s2[i] = m_s1[i];
                m_s1[i] = int'(btn[i]);
            end
        end
    end

    // Monitor: sampled on the falling edge, away from DUT updates.
    logic [NB-1:0] prev = '0;
    logic [NB-1:0] changed;
    ev_t e;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev = '0;
        end else begin
            changed = btn_o ^ prev;
            chk("rise_pulse", int'(rise_o), int'(changed & btn_o));
`ifdef DEBOUNCE_FALL_EVT_EN
            chk("fall_pulse", int'(fall_o), int'(changed & ~btn_o));
`endif
            for (int k = 0; k < NB; k++) begin
                if (changed[k]) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_commit_idx", k, -1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("commit_idx", k, e.idx);
                        chk("commit_val", int'(btn_o[k]), e.val);
                        chk("commit_cyc", cyc, e.cyc);
                    end
                end
            end
            chk("busy", int'(busy_o), int'(m_busy));
            chk("grant", int'(grant_o), m_own);
            prev = btn_o;
        end
    end

    int tpc = 0;
    initial begin
        forever begin
            @(posedge clk);
            #2;
            tp = (tpc == TP_EVERY - 1);
            tpc = (tpc + 1) % TP_EVERY;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_btn_o"}, int'(btn_o), 0);
        chk({tag, "_rise_o"}, int'(rise_o), 0);
        chk({tag, "_busy_o"}, int'(busy_o), 0);
        chk({tag, "_grant_o"}, int'(grant_o), 0);
    endtask

    int seen;
    int k_r;

    initial begin
        #3;
        check_all_zero("reset");
        tick(4);
        rst_n = 1'b1;
        tick(2);

        // Clean press on 0
        btn[0] = 1'b1;
        tick(200);
        chk("press_btn0", int'(btn_o[0]), 1);

        // Bounce on 1: high for 3 pulses then low
        btn[1] = 1'b1;
        tick(3 * TP_EVERY);
        btn[1] = 1'b0;
        tick(200);
        chk("bounce_btn1", int'(btn_o[1]), 0);

        // Release of 0
        btn[0] = 1'b0;
        tick(200);
        chk("release_btn0", int'(btn_o[0]), 0);

        // All four together, then 0 and 2 again with the pointer back at 0
        btn = 4'hF;
        tick(650);
        chk("rr_all", int'(btn_o), 15);
        btn[0] = 1'b0;
        btn[2] = 1'b0;
        tick(400);
        chk("rr_second", int'(btn_o), 10);

        // Input 2 pulses briefly while 0 owns the counter
        btn = 4'h0;
        tick(400);
        btn[0] = 1'b1;
        tick(40);
        btn[2] = 1'b1;
        tick(2 * TP_EVERY);
        btn[2] = 1'b0;
        tick(250);
        chk("waiter_btn2", int'(btn_o[2]), 0);
        chk("waiter_btn0", int'(btn_o[0]), 1);

        // Reset in the middle of a window owned by 1
        btn[1] = 1'b1;
        seen = 0;
        for (int i = 0; i < 100 && !(busy_o && grant_o == 2'd1); i++) tick(1);
        chk("midreset_grant", int'(busy_o && grant_o == 2'd1), 1);
        for (int i = 0; i < 200 && seen < 4; i++) begin
            tick(1);
            if (tp) seen++;
        end
        chk("midreset_tps", seen, 4);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        tick(3);
        rst_n = 1'b1;
        tick(400);
        chk("after_reset", int'(btn_o), 3);

        // Random toggles with random hold times
        repeat (40) begin
            k_r = int'($urandom_range(NB - 1, 0));
            btn[k_r] = ~btn[k_r];
            tick(int'($urandom_range(200, 1)));
        end
        tick(800);
        chk("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/debounce_sched.md
# debounce_sched

Multi-button debounce scheduler for the TapTempo front end. It shares one debounce counter between `NB_BTN` raw button inputs, granting it round-robin to whichever inputs disagree with their debounced state. It commits a new level only after the input has held stable for the full debounce window, measured in `tp_i` timepulses. Its outputs feed the tap/period measurement logic in place of per-button debouncers.

## Interface
- `NB_BTN`, 4: number of button inputs, 2..16.
- `PULSE_PER_NS`, 5120: period of `tp_i` in ns.
- `DEBOUNCE_PER_NS`, 20_971_520: debounce window in ns. The simulation build (`COCOTB_SIM`) uses 5120*8.
- Derived: `MAX_COUNT = DEBOUNCE_PER_NS/PULSE_PER_NS - 1`. Counter width is `$clog2(MAX_COUNT+1)`.

Ports:
- `clk_i` in 1: system clock. This is the only clock.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `tp_i` in 1: timepulse, one `clk_i` cycle wide, every `PULSE_PER_NS`.
- `btn_i` in `NB_BTN`: raw asynchronous button levels.
- `btn_o` out `NB_BTN`: debounced levels.
- `rise_o` out `NB_BTN`: one-cycle pulse on the cycle a `btn_o` bit commits 0->1.
- `busy_o` out 1: counter granted (state `S_COUNT`).
- `grant_o` out `$clog2(NB_BTN)`: index currently owning the counter. Holds the last owner when idle.

## Operation
- **Synchronizer.** Each `btn_i` bit passes a 2-flop synchronizer giving `sync[i]`. Reset value is 0.
- **Pending.** `pend[i] = sync[i] != btn_o[i]`.
- **State machine** (2 states):
  - `S_IDLE`: if any `pend` bit is set, pick the first set index searching from `rr_ptr` upward with wrap. Then load `owner` with that index, clear `counter`, and go to `S_COUNT`. If no bit is set, stay.
  - `S_COUNT`, abort: if `pend[owner]==0` (the input bounced back), go to `S_IDLE`, set `rr_ptr=owner+1` (wrapping), and leave `btn_o` unchanged. Abort has priority over counting in the same cycle.
  - `S_COUNT`, count: else if `tp_i` and `counter==MAX_COUNT`, commit `btn_o[owner]<=sync[owner]`, pulse `rise_o[owner]` if the new value is 1, go to `S_IDLE`, and set `rr_ptr=owner+1`.
  - `S_COUNT`, hold: else if `tp_i`, `counter<=counter+1`. Otherwise hold.
- **Stability window.** A commit requires `MAX_COUNT+1` timepulses observed in `S_COUNT` with the owner continuously pending.
- **Non-owner inputs.** Pending non-owner inputs wait. Their `sync` values keep updating. A pending condition that disappears before the input is granted is never committed.
- **Width rule.** `counter` never exceeds `MAX_COUNT`, so it never wraps.
- **Reset.** Reset at any time, including mid-count, returns all state to reset values: `S_IDLE`, `rr_ptr=0`, `owner=0`, `counter=0`, `btn_o=0`, `rise_o=0`, `busy_o=0`, `grant_o=0`. Inputs already high at reset release are then debounced as a 0->1 change.

## Timing
- `btn_i` edge to `pend` set: 2 cycles (synchronizer).
- `pend` set to `busy_o=1`: 1 cycle, when the counter is free.
- Commit happens on the clock edge of the `(MAX_COUNT+1)`-th `tp_i` seen in `S_COUNT`. On the following cycle:
  - `btn_o` is updated;
  - `rise_o` is high for exactly one cycle;
  - `busy_o` is 0.
- At least 1 `S_IDLE` cycle separates consecutive grants. The next grant comes no earlier than 1 cycle after commit or abort.
- A `tp_i` on the grant cycle is not counted, because `counter` is loaded that cycle.
- **Worst-case latency** for one input with all `NB_BTN` pending: `NB_BTN` windows plus `NB_BTN` idle cycles.

## Configuration
- `DEBOUNCE_FALL_EVT_EN`, when defined:
  - adds output `fall_o` (`NB_BTN`), a one-cycle pulse on a 1->0 commit, timed identically to `rise_o`.
- When not defined:
  - the port does not exist;
  - falling commits update `btn_o` only.

## Test plan
Simulation parameters: `MAX_COUNT=7`, with `tp_i` every 16 clocks.
1. **Clean press.** `btn_i[0]` goes 0->1 and holds. Required: `busy_o`/`grant_o=0` 3 cycles after the edge, `btn_o[0]=1` with a `rise_o[0]` pulse 1 cycle after the 8th counted `tp_i`, then `busy_o=0`.
2. **Bounce abort.** `btn_i[1]` goes high for 3 timepulses, then low. Required: grant of index 1 then abort to `S_IDLE`, `btn_o[1]` stays 0, no `rise_o` pulse.
3. **Round-robin.** `btn_i[3:0]` go 0->1 together. Required: commits in order 0,1,2,3, each 8 timepulses apart plus 1 idle cycle. Then a second event on 0 and 2 while `rr_ptr=0` grants 0 before 2.
4. **Release.** Case 1 is followed by a 1->0 on `btn_i[0]`. Required: `btn_o[0]=0` after 8 timepulses, no `rise_o`. With `DEBOUNCE_FALL_EVT_EN`, `fall_o[0]` pulses once.
5. **Reset mid-count.** Assert `rst_n_i=0` at timepulse 4 of a grant. Required: all outputs 0 immediately. After release with `btn_i[0]` still high, a fresh full 8-pulse window, then commit.
6. **Waiting input that clears.** While 0 counts, `btn_i[2]` pulses high for 2 timepulses. Required: index 2 is never granted and `btn_o[2]` stays 0.
